// File: rtl/kyber_pkg.sv
// Shared types and helpers for the Baby-Kyber key generator.
// mod_canon maps any signed integer onto the canonical residue range [0, q-1].
package kyber_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    COMPUTE = 2'd2,
    EMIT    = 2'd3
  } state_e;

  function automatic int mod_canon(input int x, input int q);
    int r;
    r = x % q;
    if (r < 0) r = r + q;
    return r;
  endfunction

endpackage

// File: rtl/modq_mac.sv
// Combinational modular multiply-accumulate: o_acc = (i_acc +/- i_a*i_b) mod Q.
// Inputs are canonical, so the sum of accumulator and reduced term is below 2Q.
module modq_mac #(
  parameter int Q  = 17,
  parameter int QW = $clog2(Q)
) (
  input  logic [QW-1:0] i_acc,
  input  logic [QW-1:0] i_a,
  input  logic [QW-1:0] i_b,
  input  logic          i_neg,
  output logic [QW-1:0] o_acc
);

  localparam int PW = 2 * QW;

  logic [PW-1:0] w_prod;
  logic [PW-1:0] w_red;
  logic [PW-1:0] w_term;
  logic [PW-1:0] w_sum;
  logic [PW-1:0] w_fin;

  always_comb begin
    w_prod = PW'(i_a) * PW'(i_b);
    w_red  = w_prod % PW'(Q);
    // (Q - p) mod Q: a zero product must stay zero rather than become Q
    if (i_neg && (w_red != '0)) w_term = PW'(Q) - w_red;
    else                        w_term = w_red;
    w_sum = PW'(i_acc) + w_term;
    if (w_sum >= PW'(Q)) w_fin = w_sum - PW'(Q);
    else                 w_fin = w_sum;
    o_acc = QW'(w_fin);
  end

endmodule

// File: rtl/kyber_keygen_seq.sv
// Sequential Baby-Kyber key generator: t = A*s + e mod (Q, x^N+1) with K x K modules.
// Loads s, A, e from a sample stream, runs one shared MAC per cycle, then streams t and s.
module kyber_keygen_seq
  import kyber_pkg::*;
#(
  parameter int N  = 4,
  parameter int K  = 2,
  parameter int Q  = 17,
  parameter int IW = 8,
  localparam int QW = $clog2(Q)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 clear,
  output logic                 busy,
  output logic                 done,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [IW-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [QW-1:0]        out_data,
  output logic                 out_is_sk,
  output logic                 out_last
);

  localparam int KN     = K * N;
  localparam int KKN    = K * K * N;
  localparam int NB_IN  = KN * (K + 2);
  localparam int NB_OUT = 2 * KN;
  localparam int BW     = $clog2(NB_IN);
  localparam int NW     = $clog2(N);
  localparam int KW     = (K > 1) ? $clog2(K) : 1;
  localparam int SW     = $clog2(KN);
  localparam int AW     = $clog2(KKN);

  state_e r_state;
  state_e w_state_nx;

  logic [BW-1:0] r_beat;
  logic [KW-1:0] r_i;
  logic [KW-1:0] r_j;
  logic [NW-1:0] r_k;
  logic [NW-1:0] r_m;
  logic [QW-1:0] r_acc;
  logic          r_done;

  logic [QW-1:0] r_s [KN];
  logic [QW-1:0] r_a [KKN];
  logic [QW-1:0] r_e [KN];
  logic [QW-1:0] r_t [KN];

  logic          w_in_fire;
  logic          w_out_fire;
  logic          w_last_in;
  logic          w_last_term;
  logic          w_last_mac;
  logic          w_out_last;
  logic          w_out_sk;
  logic [QW-1:0] w_in_canon;
  logic [SW-1:0] w_s_widx;
  logic [AW-1:0] w_a_widx;
  logic [SW-1:0] w_e_widx;
  logic [AW-1:0] w_a_ridx;
  logic [NW-1:0] w_km;
  logic [SW-1:0] w_s_ridx;
  logic [SW-1:0] w_t_idx;
  logic [SW-1:0] w_o_idx;
  logic          w_neg;
  logic [QW-1:0] w_mac_acc;
  logic [QW-1:0] w_mac_a;
  logic [QW-1:0] w_mac_b;
  logic [QW-1:0] w_mac_out;

  // Handshake: a beat moves on a clock edge where valid && ready are both high;
  // the producer holds valid and data steady until that edge, ready may change freely.
  assign w_in_fire  = in_valid && (r_state == LOAD);
  assign w_out_fire = out_ready && (r_state == EMIT);
  assign w_last_in  = (r_beat == BW'(NB_IN - 1));
  assign w_out_last = (r_state == EMIT) && (r_beat == BW'(NB_OUT - 1));
  assign w_out_sk   = (r_beat >= BW'(KN));

  assign w_in_canon = QW'(mod_canon(int'(in_data), Q));
  assign w_s_widx   = SW'(r_beat);
  assign w_a_widx   = AW'(r_beat - BW'(KN));
  assign w_e_widx   = SW'(r_beat - BW'(KN + KKN));
  assign w_o_idx    = w_out_sk ? SW'(r_beat - BW'(KN)) : SW'(r_beat);

  // N is a power of two, so NW-bit wraparound of k-m is exactly (k-m) mod N
  assign w_km        = r_k - r_m;
  assign w_neg       = (r_k < r_m);
  assign w_a_ridx    = AW'((int'(r_i) * K + int'(r_j)) * N + int'(r_m));
  assign w_s_ridx    = SW'(int'(r_j) * N + int'(w_km));
  assign w_t_idx     = SW'(int'(r_i) * N + int'(r_k));
  assign w_last_term = (r_j == KW'(K - 1)) && (r_m == NW'(N - 1));
  assign w_last_mac  = w_last_term && (r_i == KW'(K - 1)) && (r_k == NW'(N - 1));

  assign w_mac_acc = ((r_j == '0) && (r_m == '0)) ? r_e[w_t_idx] : r_acc;
  assign w_mac_a   = r_a[w_a_ridx];
  assign w_mac_b   = r_s[w_s_ridx];

  modq_mac #(.Q(Q), .QW(QW)) u_mac (
    .i_acc (w_mac_acc),
    .i_a   (w_mac_a),
    .i_b   (w_mac_b),
    .i_neg (w_neg),
    .o_acc (w_mac_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    busy       = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_nx = LOAD;
      end
      LOAD: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        if (w_in_fire && w_last_in) w_state_nx = COMPUTE;
      end
      COMPUTE: begin
        busy = 1'b1;
        if (w_last_mac) w_state_nx = EMIT;
      end
      EMIT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (w_out_fire && w_out_last) w_state_nx = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
    if (clear) w_state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat <= '0;
      r_i    <= '0;
      r_j    <= '0;
      r_k    <= '0;
      r_m    <= '0;
      r_acc  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_out_fire && w_out_last && !clear;
      if (clear || (r_state == IDLE)) begin
        r_beat <= '0;
        r_i    <= '0;
        r_j    <= '0;
        r_k    <= '0;
        r_m    <= '0;
      end else if (r_state == LOAD) begin
        if (w_in_fire) r_beat <= w_last_in ? '0 : r_beat + BW'(1);
      end else if (r_state == COMPUTE) begin
        r_acc <= w_mac_out;
        if (r_m == NW'(N - 1)) begin
          r_m <= '0;
          if (r_j == KW'(K - 1)) begin
            r_j <= '0;
            if (r_k == NW'(N - 1)) begin
              r_k <= '0;
              r_i <= (r_i == KW'(K - 1)) ? '0 : r_i + KW'(1);
            end else begin
              r_k <= r_k + NW'(1);
            end
          end else begin
            r_j <= r_j + KW'(1);
          end
        end else begin
          r_m <= r_m + NW'(1);
        end
      end else begin
        if (w_out_fire) r_beat <= w_out_last ? '0 : r_beat + BW'(1);
      end
    end
  end

  // Coefficient storage carries no reset; every word is rewritten before it is read
  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      if (r_beat < BW'(KN))             r_s[w_s_widx] <= w_in_canon;
      else if (r_beat < BW'(KN + KKN))  r_a[w_a_widx] <= w_in_canon;
      else                              r_e[w_e_widx] <= w_in_canon;
    end
    if ((r_state == COMPUTE) && w_last_term) r_t[w_t_idx] <= w_mac_out;
  end

  assign done      = r_done;
  assign out_last  = w_out_last;
  assign out_is_sk = out_valid && w_out_sk;
  assign out_data  = out_valid ? (w_out_sk ? r_s[w_o_idx] : r_t[w_o_idx]) : '0;

endmodule

// File: tb/tb_kyber_keygen_seq.sv
// Bench for kyber_keygen_seq: a default instance and a wide (N=8,K=3,Q=3329,IW=16) instance,
// checked against an exact integer polynomial model with immediate assertions.
module tb_kyber_keygen_seq;

  logic clk;
  logic rst_n;
  bit   sel;
  int   cyc;
  int   checks;
  int   failures;

  logic              start_c, clear_c, in_valid_c, out_ready_c;
  logic signed [15:0] in_data_c;

  logic        start_d, clear_d, in_valid_d, out_ready_d;
  logic [7:0]  in_data_d;
  logic        busy_d, done_d, in_ready_d, out_valid_d, out_is_sk_d, out_last_d;
  logic [4:0]  out_data_d;

  logic        start_w, clear_w, in_valid_w, out_ready_w;
  logic [15:0] in_data_w;
  logic        busy_w, done_w, in_ready_w, out_valid_w, out_is_sk_w, out_last_w;
  logic [11:0] out_data_w;

  logic        m_busy, m_done, m_in_ready, m_out_valid, m_out_is_sk, m_out_last;
  logic [11:0] m_out_data;

  int          s_v[24];
  int          a_v[72];
  int          e_v[24];
  int          beat_q[$];
  logic [11:0] exp_q[$];
  bit          sk_q[$];

  int dir_in[32]  = '{0, 1, -1, -1, 0, -1, 0, -1,
                      11, 16, 16, 6, 3, 6, 4, 9, 1, 10, 3, 5, 15, 9, 1, 6,
                      0, 0, 1, 0, 0, -1, 1, 0};
  int dir_out[16] = '{7, 0, 15, 16, 6, 11, 12, 10, 0, 1, 16, 16, 0, 16, 0, 16};

  assign start_d     = start_c & ~sel;
  assign clear_d     = clear_c & ~sel;
  assign in_valid_d  = in_valid_c & ~sel;
  assign out_ready_d = out_ready_c & ~sel;
  assign in_data_d   = in_data_c[7:0];
  assign start_w     = start_c & sel;
  assign clear_w     = clear_c & sel;
  assign in_valid_w  = in_valid_c & sel;
  assign out_ready_w = out_ready_c & sel;
  assign in_data_w   = in_data_c;

  assign m_busy      = sel ? busy_w      : busy_d;
  assign m_done      = sel ? done_w      : done_d;
  assign m_in_ready  = sel ? in_ready_w  : in_ready_d;
  assign m_out_valid = sel ? out_valid_w : out_valid_d;
  assign m_out_is_sk = sel ? out_is_sk_w : out_is_sk_d;
  assign m_out_last  = sel ? out_last_w  : out_last_d;
  assign m_out_data  = sel ? out_data_w  : 12'(out_data_d);

  kyber_keygen_seq #(.N(4), .K(2), .Q(17), .IW(8)) dut_d (
    .clk(clk), .rst_n(rst_n), .start(start_d), .clear(clear_d), .busy(busy_d), .done(done_d),
    .in_valid(in_valid_d), .in_ready(in_ready_d), .in_data(in_data_d),
    .out_valid(out_valid_d), .out_ready(out_ready_d), .out_data(out_data_d),
    .out_is_sk(out_is_sk_d), .out_last(out_last_d)
  );

  kyber_keygen_seq #(.N(8), .K(3), .Q(3329), .IW(16)) dut_w (
    .clk(clk), .rst_n(rst_n), .start(start_w), .clear(clear_w), .busy(busy_w), .done(done_w),
    .in_valid(in_valid_w), .in_ready(in_ready_w), .in_data(in_data_w),
    .out_valid(out_valid_w), .out_ready(out_ready_w), .out_data(out_data_w),
    .out_is_sk(out_is_sk_w), .out_last(out_last_w)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int canon(input longint x, input int q);
    longint r;
    r = x % q;
    if (r < 0) r = r + q;
    return int'(r);
  endfunction

  // Reference: exact integer negacyclic products summed per row, one reduction at the end
  task automatic build_model(input int n, input int kk, input int q);
    longint c[8];
    longint p;
    exp_q.delete();
    sk_q.delete();
    for (int i = 0; i < kk; i++) begin
      for (int x = 0; x < n; x++) c[x] = e_v[i*n+x];
      for (int j = 0; j < kk; j++)
        for (int x = 0; x < n; x++)
          for (int y = 0; y < n; y++) begin
            p = longint'(a_v[(i*kk+j)*n+x]) * longint'(s_v[j*n+y]);
            if (x + y < n) c[x+y] = c[x+y] + p;
            else           c[x+y-n] = c[x+y-n] - p;
          end
      for (int x = 0; x < n; x++) begin
        exp_q.push_back(12'(canon(c[x], q)));
        sk_q.push_back(1'b0);
      end
    end
    for (int x = 0; x < kk*n; x++) begin
      exp_q.push_back(12'(canon(longint'(s_v[x]), q)));
      sk_q.push_back(1'b1);
    end
  endtask

  task automatic fill_beats(input int n, input int kk);
    beat_q.delete();
    for (int x = 0; x < kk*n; x++) beat_q.push_back(s_v[x]);
    for (int x = 0; x < kk*kk*n; x++) beat_q.push_back(a_v[x]);
    for (int x = 0; x < kk*n; x++) beat_q.push_back(e_v[x]);
  endtask

  task automatic load_directed();
    beat_q.delete();
    exp_q.delete();
    sk_q.delete();
    for (int x = 0; x < 32; x++) beat_q.push_back(dir_in[x]);
    for (int x = 0; x < 16; x++) begin
      exp_q.push_back(12'(dir_out[x]));
      sk_q.push_back(x >= 8);
    end
  endtask

  task automatic gen_random(input int n, input int kk, input int q, input int iw);
    int lo;
    lo = -(1 << (iw - 1));
    for (int x = 0; x < kk*n; x++) s_v[x] = int'($urandom_range(0, (1 << iw) - 1)) + lo;
    for (int x = 0; x < kk*kk*n; x++) a_v[x] = int'($urandom_range(0, (1 << iw) - 1)) + lo;
    for (int x = 0; x < kk*n; x++) e_v[x] = int'($urandom_range(0, (1 << iw) - 1)) + lo;
    s_v[0] = -q + 1;
    fill_beats(n, kk);
    build_model(n, kk, q);
  endtask

  // driver: pulse start, then push every beat of beat_q through the input stream
  task automatic start_and_load(input bit throttle, output int t0);
    int  idx;
    int  budget;
    bit  fire;
    @(negedge clk);
    start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    t0 = cyc;
    check("busy_after_start", m_busy, 1);
    check("in_ready_in_load", m_in_ready, 1);
    idx = 0;
    budget = 0;
    while ((idx < beat_q.size()) && (budget < 3000)) begin
      if (throttle && ($urandom_range(0, 9) < 3)) begin
        in_valid_c = 1'b0;
      end else begin
        in_valid_c = 1'b1;
        in_data_c  = 16'(beat_q[idx]);
      end
      fire = in_valid_c && m_in_ready;
      @(negedge clk);
      budget++;
      if (fire) idx++;
    end
    in_valid_c = 1'b0;
    check("load_timeout", idx, beat_q.size());
  endtask

  // scoreboard: drain the output stream against exp_q, then check the done pulse
  task automatic emit_and_check(input int n, input int kk, input bit throttle,
                                input bit timing, input int t0);
    int          budget;
    int          left;
    bit          stalled;
    logic [11:0] held;
    logic [11:0] ed;
    bit          esk;
    budget  = 0;
    stalled = 1'b0;
    held    = '0;
    left    = exp_q.size();
    while ((left > 0) && (budget < 6000)) begin
      out_ready_c = throttle ? ($urandom_range(0, 9) >= 3) : 1'b1;
      if (m_out_valid) begin
        if (stalled) check("stable_while_stalled", m_out_data, held);
        if (out_ready_c) begin
          ed  = exp_q.pop_front();
          esk = sk_q.pop_front();
          left--;
          check("out_data", m_out_data, ed);
          check("out_is_sk", m_out_is_sk, esk);
          check("out_last", m_out_last, left == 0);
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held    = m_out_data;
        end
      end
      @(negedge clk);
      budget++;
    end
    out_ready_c = 1'b0;
    check("emit_timeout", left, 0);
    check("done_pulse", m_done, 1);
    check("busy_low_at_done", m_busy, 0);
    if (timing) check("latency", cyc - t0, n*kk*(kk+2) + kk*kk*n*n + 2*kk*n);
    @(negedge clk);
    check("done_one_cycle", m_done, 0);
  endtask

  initial begin
    int t0;
    int dcount;
    checks = 0;
    failures = 0;
    sel = 1'b0;
    rst_n = 1'b0;
    start_c = 1'b0;
    clear_c = 1'b0;
    in_valid_c = 1'b0;
    out_ready_c = 1'b0;
    in_data_c = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", m_busy, 0);
    check("rst_done", m_done, 0);
    check("rst_in_ready", m_in_ready, 0);
    check("rst_out_valid", m_out_valid, 0);
    check("rst_out_data", m_out_data, 0);
    check("rst_out_is_sk", m_out_is_sk, 0);
    check("rst_out_last", m_out_last, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // directed vector, no bubbles, exact latency
    load_directed();
    start_and_load(1'b0, t0);
    emit_and_check(4, 2, 1'b0, 1'b1, t0);

    // same vector under random throttling on both streams
    load_directed();
    start_and_load(1'b1, t0);
    emit_and_check(4, 2, 1'b1, 1'b0, t0);

    // clear at COMPUTE cycle 10
    load_directed();
    start_and_load(1'b0, t0);
    repeat (10) @(negedge clk);
    clear_c = 1'b1;
    @(negedge clk);
    clear_c = 1'b0;
    check("clear_busy", m_busy, 0);
    check("clear_in_ready", m_in_ready, 0);
    check("clear_out_valid", m_out_valid, 0);
    dcount = 0;
    repeat (80) begin
      @(negedge clk);
      if (m_done) dcount++;
    end
    check("clear_no_done", dcount, 0);
    check("clear_stays_idle", m_busy, 0);

    // start coincident with clear is dropped
    start_c = 1'b1;
    clear_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    clear_c = 1'b0;
    check("start_with_clear_dropped", m_busy, 0);

    load_directed();
    start_and_load(1'b0, t0);
    emit_and_check(4, 2, 1'b0, 1'b1, t0);

    // asynchronous reset mid-COMPUTE
    load_directed();
    start_and_load(1'b0, t0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", m_busy, 0);
    check("midrst_done", m_done, 0);
    check("midrst_out_valid", m_out_valid, 0);
    check("midrst_in_ready", m_in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    load_directed();
    start_and_load(1'b0, t0);
    emit_and_check(4, 2, 1'b0, 1'b1, t0);

    // random vectors at default parameters
    for (int r = 0; r < 4; r++) begin
      gen_random(4, 2, 17, 8);
      start_and_load(r[0], t0);
      emit_and_check(4, 2, r[0], !r[0], t0);
    end

    // wide parameter set
    sel = 1'b1;
    @(negedge clk);
    for (int r = 0; r < 6; r++) begin
      gen_random(8, 3, 3329, 16);
      start_and_load(r[0], t0);
      emit_and_check(8, 3, r[0], !r[0], t0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
